// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    SS_IDLE = 2'd0,
    SS_RUN  = 2'd1,
    SS_DONE = 2'd2
  } ss_state_e;

  localparam int SS_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor_1b.sv
// One-bit full-subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor_1b (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, behind a start/done handshake.
// Optional signed overflow output: define SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = SS_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  ss_state_e        state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             bin;
  logic             d;
  logic             bout;
  logic             last;

  full_subtractor_1b u_fs (
    .a   (sh_a[0]),
    .b   (sh_b[0]),
    .bin (bin),
    .d   (d),
    .bout(bout)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SS_IDLE;
      sh_a       <= '0;
      sh_b       <= '0;
      res        <= '0;
      cnt        <= '0;
      bin        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        SS_RUN: begin
          res  <= {d, res[WIDTH-1:1]};
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          bin  <= bout;
          cnt  <= cnt + 1'b1;
          if (last) begin
            state      <= SS_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            diff       <= {d, res[WIDTH-1:1]};
            borrow_out <= bout;
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            state <= SS_RUN;
            busy  <= 1'b1;
            sh_a  <= a;
            sh_b  <= b;
            bin   <= 1'b0;
            cnt   <= '0;
          end else begin
            state <= SS_IDLE;
          end
        end
      endcase
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  // Operand MSBs sit in bit 0 of the shifters on the final step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (state == SS_RUN && last) begin
      ovf <= (sh_a[0] ^ sh_b[0]) & (d ^ sh_a[0]);
    end
  end
`endif

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing `a - b` one bit per clock, LSB first, through a single 1-bit full-subtractor cell and a registered borrow. It is the inverse-operation companion to the team's 1-bit full-adder datapath. It sits behind a start/done handshake so the full subtraction fits in a few flops and one cell on a small tile.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request a subtraction. Sampled only in IDLE or DONE.
- `a`, input, WIDTH: minuend. Latched on an accepted `start`.
- `b`, input, WIDTH: subtrahend. Latched on an accepted `start`.
- `busy`, output, 1: high while in RUN.
- `done`, output, 1: one-cycle pulse; the result is valid from this cycle on.
- `diff`, output, WIDTH: `(a - b) mod 2^WIDTH`. Holds until the next completion.
- `borrow_out`, output, 1: set when unsigned `a < b`. Holds with `diff`.

## Operation
- FSM has three states: IDLE, RUN and DONE. Reset enters IDLE.
- Reset values: `busy`=0, `done`=0, `diff`=0, `borrow_out`=0, internal borrow=0, bit counter=0, operand shift registers=0.
- IDLE → RUN on `start`=1:
  - `a` and `b` load into shift registers.
  - Borrow clears to 0 and the counter clears to 0.
- Each RUN edge:
  - Computes `d = a0 ^ b0 ^ bin`.
  - Computes `bout = (~a0 & b0) | (~(a0 ^ b0) & bin)`.
  - `a0` and `b0` are the current operand LSBs.
  - `d` shifts into the result register from the MSB end; the operands shift right; borrow ← `bout`; the counter increments.
- RUN → DONE on the edge that processes bit WIDTH-1:
  - `diff` ← completed result, including that final bit.
  - `borrow_out` ← final `bout`.
- DONE lasts exactly one cycle with `done`=1.
  - DONE → RUN if `start`=1, which gives back-to-back operation.
  - Otherwise DONE → IDLE.
- `start` while in RUN is ignored. The in-flight operation completes unaffected.
- `diff` and `borrow_out` change only on DONE entry. They never expose partial results.
- Changes to `a` and `b` after acceptance have no effect.
- Reset asserted mid-RUN or in DONE: immediate return to IDLE with every output at its reset value. No `done` is produced for the aborted operation.

## Timing
- If `start` is accepted at edge k, then `busy`=1 after edge k.
- `busy`=0 and `done`=1 after edge k+WIDTH. The result is visible in that same cycle.
- Latency from accepting edge to `done` is WIDTH cycles.
- Throughput is one result per WIDTH+1 cycles when `start` is held high.
- `busy` and `done` are never high together.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro `SERIAL_SUBTRACTOR_OVF_EN`.
- Defined:
  - Adds output port `ovf`, 1 bit, reset 0.
  - `ovf` is the signed two's-complement overflow, set when `a[MSB] != b[MSB]` and `diff[MSB] != a[MSB]`.
  - `ovf` updates and holds exactly like `borrow_out`.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package `serial_subtractor_pkg` contains:
  - The state enum (IDLE, RUN, DONE).
  - Default-width constant `SS_DEFAULT_WIDTH` = 8.
- The counter width is `$clog2(WIDTH)`, derived locally.
- One sub-module, `full_subtractor_1b`:
  - Purely combinational.
  - Ports `a`, `b`, `bin`, `d`, `bout`.
  - Instantiated once in the datapath.

## Test plan
- Reset, then `a`=8'h0F, `b`=8'h05, `start` pulse → `done` 8 cycles later with `diff`=8'h0A and `borrow_out`=0; `busy` high for exactly 8 cycles.
- `a`=8'h05, `b`=8'h0F → `diff`=8'hF6, `borrow_out`=1. Also `a`=8'h00, `b`=8'h00 → `diff`=8'h00, `borrow_out`=0.
- `start` re-pulsed with new operands mid-RUN → ignored; the original result appears on schedule, and `diff` is unchanged until `done`.
- `start` held high with `a`=8'hFF, `b`=8'h01 → `diff`=8'hFE on each `done`, with pulses spaced 9 cycles apart.
- `rst` asserted at RUN bit 4 → outputs 0 immediately and state IDLE; no `done` appears; the next operation is correct.
- With `SERIAL_SUBTRACTOR_OVF_EN`: 8'h80 − 8'h01 → `diff`=8'h7F, `ovf`=1, `borrow_out`=0. Also 8'h7F − 8'hFF → `diff`=8'h80, `ovf`=1, `borrow_out`=1.
